// File: rtl/ground_scroller.sv
// Ground strip pixel source for the dinosaur game: a horizon line plus pebble texture,
// scrolled once per frame. It also exports the scroll offset and a saturating odometer.
module ground_scroller #(
  parameter int GROUND_ROW = 400
) (
  input  logic        vga_clk,
  input  logic        clrn,
  input  logic [8:0]  row_addr,
  input  logic [9:0]  col_addr,
  input  logic        rdn,
  input  logic        vs,
  input  logic        run,
  input  logic [2:0]  speed,
  output logic        px_ground,
  output logic [9:0]  scroll_pos,
  output logic [15:0] distance
);

  localparam logic [8:0] ROW_LO = 9'(GROUND_ROW);
  localparam logic [8:0] ROW_HI = 9'(GROUND_ROW + 7);

  logic        vs_d;
  logic        tick;
  logic        tick_q;
  logic [2:0]  step_q;
  logic [16:0] dist_sum;

  // vs_d resets high so a vs already high at reset release is not seen as an edge.
  assign tick = vs & ~vs_d;

  // run/speed are captured on the tick cycle; the offset moves one cycle later.
  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      vs_d   <= 1'b1;
      tick_q <= 1'b0;
      step_q <= 3'd0;
    end else begin
      vs_d   <= vs;
      tick_q <= tick;
      if (tick) begin
        step_q <= run ? speed : 3'd0;
      end
    end
  end

  assign dist_sum = {1'b0, distance} + {14'd0, step_q};

  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      scroll_pos <= 10'd0;
      distance   <= 16'd0;
    end else if (tick_q) begin
      scroll_pos <= scroll_pos + {7'd0, step_q};
      distance   <= dist_sum[16] ? 16'hffff : dist_sum[15:0];
    end
  end

  logic [9:0] x;
  logic [8:0] r;
  logic       in_strip;

  assign x        = col_addr + scroll_pos;
  assign r        = row_addr - ROW_LO;
  assign in_strip = (row_addr >= ROW_LO) && (row_addr <= ROW_HI);

  always_comb begin
    px_ground = 1'b0;
    if (!rdn && in_strip) begin
      case (r[2:0])
        3'd0, 3'd1: px_ground = 1'b1;
        3'd3:       px_ground = (x[5:0] < 6'd3);
        3'd5:       px_ground = (x[6:0] >= 7'd40) && (x[6:0] <= 7'd43);
        3'd7:       px_ground = (x[7:0] >= 8'd100) && (x[7:0] <= 8'd101);
        default:    px_ground = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_ground_scroller.sv
// Self-checking bench for ground_scroller: a scoreboard of expected offset/odometer
// values and pixel values, each built from a small reference model.
module tb_ground_scroller;

  localparam int GR = 400;

  logic        vga_clk = 1'b0;
  logic        clrn = 1'b0;
  logic [8:0]  row_addr = '0;
  logic [9:0]  col_addr = '0;
  logic        rdn = 1'b1;
  logic        vs = 1'b1;
  logic        run = 1'b0;
  logic [2:0]  speed = '0;
  logic        px_ground;
  logic [9:0]  scroll_pos;
  logic [15:0] distance;

  int checks = 0;
  int failures = 0;
  int exp_scroll = 0;
  int exp_dist = 0;
  logic [25:0] exp_q[$];
  logic [0:0]  pix_q[$];

  ground_scroller #(.GROUND_ROW(GR)) dut (
    .vga_clk(vga_clk), .clrn(clrn), .row_addr(row_addr), .col_addr(col_addr),
    .rdn(rdn), .vs(vs), .run(run), .speed(speed),
    .px_ground(px_ground), .scroll_pos(scroll_pos), .distance(distance)
  );

  // clock / reset / watchdog
  always #20 vga_clk = ~vga_clk;

  initial begin
    #(40 * 200000);
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  function automatic logic px_model(int row, int col, logic rdn_v, int pos);
    int x, r;
    x = (col + pos) % 1024;
    if (rdn_v) return 1'b0;
    if (row < GR || row > GR + 7) return 1'b0;
    r = row - GR;
    case (r)
      0, 1: return 1'b1;
      3: return (x % 64) < 3;
      5: return ((x % 128) >= 40) && ((x % 128) <= 43);
      7: return ((x % 256) >= 100) && ((x % 256) <= 101);
      default: return 1'b0;
    endcase
  endfunction

  // driver tasks
  task automatic do_reset();
    @(negedge vga_clk);
    vs = 1'b0;
    clrn = 1'b0;
    @(negedge vga_clk);
    clrn = 1'b1;
    exp_scroll = 0;
    exp_dist = 0;
    exp_q.delete();
  endtask

  // One vs pulse; run/speed are scrambled right after the sampling edge.
  task automatic frame_tick(input logic r, input logic [2:0] s);
    int step;
    @(negedge vga_clk);
    vs = 1'b1;
    run = r;
    speed = s;
    @(negedge vga_clk);
    run = ~r;
    speed = ~s;
    @(negedge vga_clk);
    vs = 1'b0;
    step = r ? int'(s) : 0;
    exp_scroll = (exp_scroll + step) % 1024;
    exp_dist = (exp_dist + step > 65535) ? 65535 : exp_dist + step;
    exp_q.push_back({16'(exp_dist), 10'(exp_scroll)});
  endtask

  task automatic drive_px(input int row, input int col, input logic rdn_v);
    row_addr = 9'(row);
    col_addr = 10'(col);
    rdn = rdn_v;
    pix_q.push_back(px_model(row, col, rdn_v, exp_scroll));
    #1;
  endtask

  // tests
  task automatic test_reset();
    int rows[3] = '{400, 399, 408};
    logic [0:0] e, got;
    vs = 1'b1; run = 1'b1; speed = 3'd5;
    #5;
    checks++;
    if (scroll_pos !== 10'd0 || distance !== 16'd0) begin
      failures++;
      $display("FAIL reset_hold: scroll=%0d dist=%0d required 0/0", scroll_pos, distance);
    end
    @(negedge vga_clk);
    clrn = 1'b1;
    repeat (5) @(negedge vga_clk);
    checks++;
    if (scroll_pos !== 10'd0 || distance !== 16'd0) begin
      failures++;
      $display("FAIL no_spurious_tick: scroll=%0d dist=%0d required 0/0", scroll_pos, distance);
    end
    vs = 1'b0;
    foreach (rows[i]) begin
      drive_px(rows[i], 10, 1'b0);
      got = px_ground;
      e = pix_q.pop_front();
      checks++;
      if (got !== e || e !== (i == 0 ? 1'b1 : 1'b0)) begin
        failures++;
        $display("FAIL reset_px row=%0d: got=%0b required=%0b", rows[i], got, e);
      end
    end
  endtask

  task automatic test_static();
    int   rows[9] = '{403, 403, 403, 403, 405, 405, 405, 407, 402};
    int   cols[9] = '{0, 1, 2, 3, 40, 43, 44, 100, 0};
    logic want[9] = '{1, 1, 1, 0, 1, 1, 0, 1, 0};
    logic [0:0] e, got;
    foreach (rows[i]) begin
      drive_px(rows[i], cols[i], 1'b0);
      got = px_ground;
      e = pix_q.pop_front();
      checks++;
      if (got !== e || e !== want[i]) begin
        failures++;
        $display("FAIL static_px row=%0d col=%0d: got=%0b required=%0b", rows[i], cols[i], got, want[i]);
      end
    end
    drive_px(400, 10, 1'b1);
    got = px_ground;
    e = pix_q.pop_front();
    checks++;
    if (got !== e || e !== 1'b0) begin
      failures++;
      $display("FAIL rdn_blank: got=%0b required=0", got);
    end
  endtask

  task automatic test_latency();
    int old;
    old = exp_scroll;
    @(negedge vga_clk);
    vs = 1'b1; run = 1'b1; speed = 3'd1;
    @(negedge vga_clk);
    checks++;
    if (scroll_pos !== 10'(old)) begin
      failures++;
      $display("FAIL latency_early: scroll=%0d required=%0d", scroll_pos, old);
    end
    @(negedge vga_clk);
    vs = 1'b0;
    exp_scroll = (old + 1) % 1024;
    exp_dist = exp_dist + 1;
    checks++;
    if (scroll_pos !== 10'(exp_scroll) || distance !== 16'(exp_dist)) begin
      failures++;
      $display("FAIL latency_update: scroll=%0d dist=%0d required=%0d/%0d",
               scroll_pos, distance, exp_scroll, exp_dist);
    end
  endtask

  task automatic test_scroll();
    logic [25:0] e;
    logic [0:0]  pe, got;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      frame_tick(1'b1, 3'd5);
      e = exp_q.pop_front();
      checks++;
      if ({distance, scroll_pos} !== e) begin
        failures++;
        $display("FAIL scroll_tick%0d: dist=%0d scroll=%0d required=%0d/%0d",
                 i, distance, scroll_pos, e[25:10], e[9:0]);
      end
    end
    checks++;
    if (scroll_pos !== 10'd15 || distance !== 16'd15) begin
      failures++;
      $display("FAIL scroll_15: scroll=%0d dist=%0d required 15/15", scroll_pos, distance);
    end
    for (int c = 48; c <= 49; c++) begin
      drive_px(403, c, 1'b0);
      got = px_ground;
      pe = pix_q.pop_front();
      checks++;
      if (got !== pe || pe !== (c == 49 ? 1'b1 : 1'b0)) begin
        failures++;
        $display("FAIL scrolled_px col=%0d: got=%0b required=%0b", c, got, pe);
      end
    end
  endtask

  task automatic test_wrap();
    logic [25:0] e;
    int bad = 0;
    do_reset();
    for (int i = 0; i < 147; i++) begin
      frame_tick(1'b1, 3'd7);
      e = exp_q.pop_front();
      checks++;
      if ({distance, scroll_pos} !== e) begin
        failures++;
        if (bad++ < 5)
          $display("FAIL wrap_tick%0d: dist=%0d scroll=%0d required=%0d/%0d",
                   i, distance, scroll_pos, e[25:10], e[9:0]);
      end
    end
    checks++;
    if (scroll_pos !== 10'd5 || distance !== 16'd1029) begin
      failures++;
      $display("FAIL wrap_final: scroll=%0d dist=%0d required 5/1029", scroll_pos, distance);
    end
  endtask

  task automatic test_sampling();
    logic [25:0] e;
    int start;
    // between-tick changes are ignored
    @(negedge vga_clk); speed = 3'd7; run = 1'b0;
    @(negedge vga_clk); speed = 3'd1; run = 1'b1;
    @(negedge vga_clk); speed = 3'd7;
    start = exp_scroll;
    frame_tick(1'b1, 3'd2);
    e = exp_q.pop_front();
    checks++;
    if ({distance, scroll_pos} !== e || 10'(scroll_pos - 10'(start)) !== 10'd2) begin
      failures++;
      $display("FAIL sample_step2: dist=%0d scroll=%0d required=%0d/%0d",
               distance, scroll_pos, e[25:10], e[9:0]);
    end
    // long vs high gives one step
    @(negedge vga_clk);
    vs = 1'b1; run = 1'b1; speed = 3'd3;
    @(negedge vga_clk);
    speed = 3'd6;
    repeat (1000) @(negedge vga_clk);
    vs = 1'b0;
    exp_scroll = (exp_scroll + 3) % 1024;
    exp_dist = exp_dist + 3;
    exp_q.push_back({16'(exp_dist), 10'(exp_scroll)});
    e = exp_q.pop_front();
    checks++;
    if ({distance, scroll_pos} !== e) begin
      failures++;
      $display("FAIL vs_hold: dist=%0d scroll=%0d required=%0d/%0d",
               distance, scroll_pos, e[25:10], e[9:0]);
    end
    // stopped game
    frame_tick(1'b0, 3'd7);
    e = exp_q.pop_front();
    checks++;
    if ({distance, scroll_pos} !== e) begin
      failures++;
      $display("FAIL run_off: dist=%0d scroll=%0d required=%0d/%0d",
               distance, scroll_pos, e[25:10], e[9:0]);
    end
  endtask

  task automatic test_random_pixels();
    logic [0:0] e, got;
    int row, col;
    logic rv;
    for (int i = 0; i < 40; i++) begin
      row = $urandom_range(GR - 4, GR + 11);
      col = $urandom_range(0, 639);
      rv = ($urandom_range(0, 7) == 0);
      drive_px(row, col, rv);
      got = px_ground;
      e = pix_q.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL rand_px row=%0d col=%0d rdn=%0b pos=%0d: got=%0b required=%0b",
                 row, col, rv, exp_scroll, got, e);
      end
    end
  endtask

  task automatic test_saturation();
    logic [25:0] e;
    int bad = 0;
    do_reset();
    for (int i = 0; i < 9366; i++) begin
      frame_tick(1'b1, 3'd7);
      e = exp_q.pop_front();
      checks++;
      if ({distance, scroll_pos} !== e) begin
        failures++;
        if (bad++ < 5)
          $display("FAIL sat_tick%0d: dist=%0d scroll=%0d required=%0d/%0d",
                   i, distance, scroll_pos, e[25:10], e[9:0]);
      end
      if (i == 9362) begin
        checks++;
        if (distance !== 16'hffff || scroll_pos !== 10'd5) begin
          failures++;
          $display("FAIL sat_reach: dist=%0d scroll=%0d required 65535/5", distance, scroll_pos);
        end
      end
    end
    checks++;
    if (distance !== 16'hffff || scroll_pos !== 10'd26) begin
      failures++;
      $display("FAIL sat_hold: dist=%0d scroll=%0d required 65535/26", distance, scroll_pos);
    end
  endtask

  task automatic test_async_reset();
    @(posedge vga_clk);
    #7;
    clrn = 1'b0;
    #1;
    checks++;
    if (scroll_pos !== 10'd0 || distance !== 16'd0) begin
      failures++;
      $display("FAIL async_reset: scroll=%0d dist=%0d required 0/0", scroll_pos, distance);
    end
    @(negedge vga_clk);
    clrn = 1'b1;
    exp_scroll = 0;
    exp_dist = 0;
  endtask

  initial begin
    test_reset();
    test_static();
    test_latency();
    test_scroll();
    test_wrap();
    test_sampling();
    test_random_pixels();
    test_saturation();
    test_random_pixels();
    test_async_reset();
    test_random_pixels();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
